// File: rtl/rgb_stream_packer_pkg.sv
// Shared types and helpers for the pixel-stream packer.
package vid_stream_pkg;

    typedef enum logic {
        ACCUM,
        FLUSH
    } pack_state_t;

    localparam int unsigned DEF_PIX_PER_BEAT = 8;
    localparam int unsigned DEF_BPP          = 3;
    localparam int unsigned DEF_OUT_BYTES    = 32;

    // Derived sizes for the default RGB888 x8 -> 256-bit configuration
    localparam int unsigned IN_BYTES = DEF_PIX_PER_BEAT * DEF_BPP;
    localparam int unsigned CW       = $clog2(DEF_OUT_BYTES) + 1;

    // Widest byte-enable vector keep_mask can produce; callers cast down
    localparam int unsigned MAX_KEEP = 256;

    // Contiguous byte enables: the low n bits set
    function automatic logic [MAX_KEEP-1:0] keep_mask(input int unsigned n);
        logic [MAX_KEEP-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_KEEP; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/rgb_stream_packer_if.sv
// Pixel-in / packed-word-out AXI4-Stream signal bundle.
interface rgb_stream_packer_if #(
    parameter int unsigned S_BYTES = 24,
    parameter int unsigned M_BYTES = 32
);
    logic [S_BYTES*8-1:0] s_tdata;
    logic                 s_tvalid;
    logic                 s_tready;
    logic                 s_tlast;
    logic                 s_tuser;

    logic [M_BYTES*8-1:0] m_tdata;
    logic [M_BYTES-1:0]   m_tkeep;
    logic                 m_tlast;
    logic                 m_tuser;
    logic                 m_tvalid;
    logic                 m_tready;

    // Packer side
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid
    );

    // Pixel source / downstream sink side
    modport master (
        output s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid
    );
endinterface

// File: rtl/rgb_stream_packer_pixel_byte_swap.sv
// Per-pixel byte reordering (e.g. BGR <-> RGB) of one input beat.
module pixel_byte_swap #(
    parameter int unsigned PIX_PER_BEAT  = 8,
    parameter int unsigned BPP           = 3,
    parameter int unsigned SWAP_CHANNELS = 1
) (
    input  logic [PIX_PER_BEAT*BPP*8-1:0] din,
    output logic [PIX_PER_BEAT*BPP*8-1:0] dout
);

    // With swapping, byte BPP-1 of each pixel becomes that pixel's first byte
    always_comb begin
        dout = '0;
        for (int unsigned p = 0; p < PIX_PER_BEAT; p++) begin
            for (int unsigned b = 0; b < BPP; b++) begin
                dout[(p*BPP + b)*8 +: 8] =
                    din[(p*BPP + ((SWAP_CHANNELS != 0) ? (BPP - 1 - b) : b))*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/rgb_stream_packer.sv
// Packs pixel beats into wide AXI4-Stream words with a registered output,
// partial last word per line, two-word EOL flush and SOF resync.
module rgb_stream_packer
    import vid_stream_pkg::*;
#(
    parameter int unsigned PIX_PER_BEAT  = DEF_PIX_PER_BEAT,
    parameter int unsigned BPP           = DEF_BPP,
    parameter int unsigned OUT_BYTES     = DEF_OUT_BYTES,
    parameter int unsigned SWAP_CHANNELS = 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    rgb_stream_packer_if.slave  bus,
    output logic                sof_drop
);

    localparam int unsigned IN_B  = PIX_PER_BEAT * BPP;
    localparam int unsigned RES_W = $clog2(OUT_BYTES) + 1;
    localparam int unsigned OW    = OUT_BYTES * 8;

    logic [IN_B*8-1:0]    swapped;
    pack_state_t          state;
    logic [RES_W-1:0]     res_cnt;
    logic [OW-1:0]        res_buf;
    logic                 pend_sof;

    logic [2*OW-1:0]      cat;
    logic [2*OW-1:0]      beat_ext;
    int unsigned          base_cnt;
    int unsigned          tot;
    logic                 emit_needed;
    logic                 accept;
    logic                 sof_eff;
    logic [OUT_BYTES-1:0] keep_tot;
    logic [OUT_BYTES-1:0] keep_res;

    pixel_byte_swap #(
        .PIX_PER_BEAT  (PIX_PER_BEAT),
        .BPP           (BPP),
        .SWAP_CHANNELS (SWAP_CHANNELS)
    ) u_swap (
        .din  (bus.s_tdata),
        .dout (swapped)
    );

    // Append the beat behind the residue (residue ignored on SOF) and decide handshake
    always_comb begin
        base_cnt    = bus.s_tuser ? 0 : 32'(res_cnt);
        tot         = base_cnt + IN_B;
        cat         = '0;
        cat[OW-1:0] = bus.s_tuser ? '0 : res_buf;
        beat_ext    = '0;
        beat_ext[IN_B*8-1:0] = swapped;
        cat         = cat | (beat_ext << (base_cnt * 8));
        emit_needed = bus.s_tlast | (tot >= OUT_BYTES);
        keep_tot    = OUT_BYTES'(keep_mask(tot));
        keep_res    = OUT_BYTES'(keep_mask(32'(res_cnt)));
        sof_eff     = bus.s_tuser | pend_sof;
        bus.s_tready = (state == ACCUM) & (!bus.m_tvalid | bus.m_tready | !emit_needed);
        accept      = bus.s_tvalid & bus.s_tready;
    end

    // FSM, residue buffer and output register stage
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state        <= ACCUM;
            res_cnt      <= '0;
            res_buf      <= '0;
            pend_sof     <= 1'b0;
            sof_drop     <= 1'b0;
            bus.m_tvalid <= 1'b0;
            bus.m_tlast  <= 1'b0;
            bus.m_tuser  <= 1'b0;
            bus.m_tkeep  <= '0;
            bus.m_tdata  <= '0;
        end else begin
            sof_drop <= 1'b0;
            if (bus.m_tvalid && bus.m_tready) begin
                bus.m_tvalid <= 1'b0;
            end
            if (state == FLUSH) begin
                if (!bus.m_tvalid || bus.m_tready) begin
                    bus.m_tvalid <= 1'b1;
                    bus.m_tdata  <= res_buf;
                    bus.m_tkeep  <= keep_res;
                    bus.m_tlast  <= 1'b1;
                    bus.m_tuser  <= pend_sof;
                    pend_sof     <= 1'b0;
                    res_cnt      <= '0;
                    res_buf      <= '0;
                    state        <= ACCUM;
                end
            end else if (accept) begin
                sof_drop <= bus.s_tuser && (res_cnt != '0);
                if (emit_needed) begin
                    bus.m_tvalid <= 1'b1;
                    bus.m_tdata  <= cat[OW-1:0];
                    bus.m_tuser  <= sof_eff;
                    pend_sof     <= 1'b0;
                    if (bus.s_tlast && (tot <= OUT_BYTES)) begin
                        bus.m_tkeep <= keep_tot;
                        bus.m_tlast <= 1'b1;
                        res_cnt     <= '0;
                        res_buf     <= '0;
                    end else begin
                        // Full word now; on EOL the leftover goes out from FLUSH
                        bus.m_tkeep <= '1;
                        bus.m_tlast <= 1'b0;
                        res_cnt     <= RES_W'(tot - OUT_BYTES);
                        res_buf     <= cat[2*OW-1:OW];
                        if (bus.s_tlast) begin
                            state <= FLUSH;
                        end
                    end
                end else begin
                    res_buf  <= cat[OW-1:0];
                    res_cnt  <= RES_W'(tot);
                    pend_sof <= sof_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Bench for rgb_stream_packer: default RGB888 instance with a byte-level
// scoreboard, plus an RGBA8888 (IN=OUT) instance for the 1:1 and reset cases.
module tb_rgb_stream_packer;
    import vid_stream_pkg::*;

    localparam int unsigned OB = 32;

    logic aclk = 1'b0;
    logic aresetn;
    logic sof_drop;
    logic sof_drop4;

    always #5 aclk = ~aclk;

    rgb_stream_packer_if #(.S_BYTES(IN_BYTES), .M_BYTES(OB)) bus ();
    rgb_stream_packer_if #(.S_BYTES(32),       .M_BYTES(32)) bus4 ();

    rgb_stream_packer #(
        .PIX_PER_BEAT(8), .BPP(3), .OUT_BYTES(32), .SWAP_CHANNELS(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus), .sof_drop(sof_drop)
    );

    rgb_stream_packer #(
        .PIX_PER_BEAT(8), .BPP(4), .OUT_BYTES(32), .SWAP_CHANNELS(1)
    ) dut4 (
        .aclk(aclk), .aresetn(aresetn), .bus(bus4), .sof_drop(sof_drop4)
    );

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic         user;
    } word_t;

    word_t        exp_q[$];
    byte unsigned line_q[$];
    bit           sof_pend   = 1'b0;
    bit           rand_ready = 1'b0;
    int           errors     = 0;
    int           checks     = 0;
    int           words_seen = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void push_word(input int n, input bit last);
        word_t w;
        w.data = '0;
        w.keep = '0;
        for (int i = 0; i < n; i++) begin
            w.data[i*8 +: 8] = line_q.pop_front();
            w.keep[i] = 1'b1;
        end
        w.last = last;
        w.user = sof_pend;
        sof_pend = 1'b0;
        exp_q.push_back(w);
    endfunction

    // Returns the expected sof_drop pulse for this beat
    function automatic bit model_beat(input logic [191:0] d, input bit last, input bit user);
        bit drop;
        drop = user && (line_q.size() != 0);
        if (user) begin
            line_q.delete();
            sof_pend = 1'b1;
        end
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 3; c++) begin
                line_q.push_back(d[(p*3 + 2 - c)*8 +: 8]);
            end
        end
        if (!last) begin
            if (line_q.size() >= 32) push_word(32, 1'b0);
        end else begin
            while (line_q.size() > 32) push_word(32, 1'b0);
            push_word(line_q.size(), 1'b1);
        end
        return drop;
    endfunction

    function automatic logic [255:0] swap4(input logic [255:0] d);
        logic [255:0] r;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 4; c++) begin
                r[(p*4 + c)*8 +: 8] = d[(p*4 + 3 - c)*8 +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [191:0] pattern(input int base);
        logic [191:0] d;
        for (int i = 0; i < 24; i++) d[i*8 +: 8] = 8'(base + i);
        return d;
    endfunction

    // ---------------- output monitor ----------------
    bit    held = 1'b0;
    word_t held_w;

    always @(negedge aclk) begin
        if (!aresetn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", bus.m_tvalid, 1'b1);
                chk("hold_data",  bus.m_tdata,  held_w.data);
                chk("hold_keep",  bus.m_tkeep,  held_w.keep);
                chk("hold_last",  bus.m_tlast,  held_w.last);
                chk("hold_user",  bus.m_tuser,  held_w.user);
            end
            if (bus.m_tvalid && bus.m_tready) begin
                words_seen++;
                chk("word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    word_t e;
                    logic [255:0] bm;
                    e = exp_q.pop_front();
                    for (int i = 0; i < 32; i++) bm[i*8 +: 8] = {8{e.keep[i]}};
                    chk("word_data", bus.m_tdata & bm, e.data);
                    chk("word_keep", bus.m_tkeep, e.keep);
                    chk("word_last", bus.m_tlast, e.last);
                    chk("word_user", bus.m_tuser, e.user);
                end
            end
            held = bus.m_tvalid && !bus.m_tready;
            held_w.data = bus.m_tdata;
            held_w.keep = bus.m_tkeep;
            held_w.last = bus.m_tlast;
            held_w.user = bus.m_tuser;
        end
    end

    // Downstream ready: always 1 unless the random phase is active
    initial begin
        bus.m_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            bus.m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers ----------------
    // Called and returns at posedge+1
    task automatic send(input logic [191:0] d, input bit last, input bit user, output int stalls);
        bit acc;
        bit drop;
        acc    = 1'b0;
        drop   = 1'b0;
        stalls = 0;
        bus.s_tdata  = d;
        bus.s_tlast  = last;
        bus.s_tuser  = user;
        bus.s_tvalid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge aclk);
            if (bus.s_tready) begin
                drop = model_beat(d, last, user);
                acc  = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge aclk);
            #1;
        end
        bus.s_tvalid = 1'b0;
        chk("beat_accepted", acc, 1'b1);
        if (acc) chk("sof_drop", sof_drop, drop);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(posedge aclk);
        @(posedge aclk);
        #1;
        chk(tag, exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int st;
        int st_sum;
        int w0;
        logic [255:0] d4;

        aresetn       = 1'b0;
        bus.s_tvalid  = 1'b0;
        bus.s_tdata   = '0;
        bus.s_tlast   = 1'b0;
        bus.s_tuser   = 1'b0;
        bus4.s_tvalid = 1'b0;
        bus4.s_tdata  = '0;
        bus4.s_tlast  = 1'b0;
        bus4.s_tuser  = 1'b0;
        bus4.m_tready = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", bus.m_tvalid, 1'b0);
        chk("rst_m_tlast",  bus.m_tlast,  1'b0);
        chk("rst_m_tuser",  bus.m_tuser,  1'b0);
        chk("rst_m_tkeep",  bus.m_tkeep,  32'h0);
        chk("rst_sof_drop", sof_drop,     1'b0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("idle_s_tready", bus.s_tready, 1'b1);

        // 96 B line: 3 full words, tlast on the third
        w0 = words_seen;
        st_sum = 0;
        for (int b = 0; b < 4; b++) begin
            send(pattern(b * 24), b == 3, b == 0, st);
            st_sum += st;
        end
        drain("drain_96");
        chk("words_96", words_seen - w0, 3);
        chk("stalls_96", st_sum, 0);

        // 120 B line: 4 words, last keeps 24 bytes
        w0 = words_seen;
        for (int b = 0; b < 5; b++) send(pattern(100 + b * 24), b == 4, 1'b0, st);
        drain("drain_120");
        chk("words_120", words_seen - w0, 4);

        // 48 B line: two-word EOL, next beat stalls exactly one cycle
        w0 = words_seen;
        send(pattern(7), 1'b0, 1'b0, st);
        chk("stall_48_b1", st, 0);
        send(pattern(31), 1'b1, 1'b0, st);
        chk("stall_48_b2", st, 0);
        send(pattern(55), 1'b1, 1'b0, st);
        chk("flush_stall", st, 1);
        drain("drain_48");
        chk("words_48", words_seen - w0, 3);

        // SOF mid-line: residue of 24 bytes is dropped
        w0 = words_seen;
        send(pattern(200), 1'b0, 1'b0, st);
        send(pattern(60), 1'b1, 1'b1, st);
        @(posedge aclk);
        #1;
        chk("sof_drop_width", sof_drop, 1'b0);
        drain("drain_sof");
        chk("words_sof", words_seen - w0, 1);

        // Random lines with 50% downstream backpressure
        rand_ready = 1'b1;
        for (int l = 0; l < 64; l++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                logic [191:0] d;
                bit u;
                d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                u = (b == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
                send(d, b == nb - 1, u, st);
            end
        end
        drain("drain_random");
        rand_ready = 1'b0;
        @(posedge aclk);
        #1;

        // RGBA8888 1:1 word, held under backpressure
        d4 = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        bus4.m_tready = 1'b0;
        bus4.s_tdata  = d4;
        bus4.s_tlast  = 1'b0;
        bus4.s_tvalid = 1'b1;
        @(negedge aclk);
        chk("b4_s_tready", bus4.s_tready, 1'b1);
        @(posedge aclk);
        #1;
        bus4.s_tvalid = 1'b0;
        chk("b4_m_tvalid", bus4.m_tvalid, 1'b1);
        chk("b4_m_tdata",  bus4.m_tdata,  swap4(d4));
        chk("b4_m_tkeep",  bus4.m_tkeep,  32'hFFFF_FFFF);
        chk("b4_m_tlast",  bus4.m_tlast,  1'b0);

        // Default instance left mid-line with 24 residue bytes, then reset both
        send(pattern(90), 1'b0, 1'b0, st);
        aresetn = 1'b0;
        line_q.delete();
        sof_pend = 1'b0;
        @(posedge aclk);
        #1;
        chk("rst4_m_tvalid", bus4.m_tvalid, 1'b0);
        chk("rst4_m_tkeep",  bus4.m_tkeep,  32'h0);
        chk("rst_mid_tvalid", bus.m_tvalid, 1'b0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // After reset the old residue must not reappear
        w0 = words_seen;
        send(pattern(150), 1'b1, 1'b0, st);
        drain("drain_post_rst");
        chk("words_post_rst", words_seen - w0, 1);

        bus4.m_tready = 1'b1;
        d4 = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        bus4.s_tdata  = d4;
        bus4.s_tlast  = 1'b1;
        bus4.s_tvalid = 1'b1;
        @(negedge aclk);
        chk("b4_eol_ready", bus4.s_tready, 1'b1);
        @(posedge aclk);
        #1;
        bus4.s_tvalid = 1'b0;
        chk("b4_eol_tvalid", bus4.m_tvalid, 1'b1);
        chk("b4_eol_tdata",  bus4.m_tdata,  swap4(d4));
        chk("b4_eol_tkeep",  bus4.m_tkeep,  32'hFFFF_FFFF);
        chk("b4_eol_tlast",  bus4.m_tlast,  1'b1);
        chk("b4_sof_drop",   sof_drop4,     1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
